dht11_sensor_ctrl: RTL and testbench

Single-wire DHT11 host controller that sits upstream of the stopwatch/watch data path in the temperature top. On a start request it drives the host start pulse, receives the sensor's 40-bit frame, and verifies the checksum. Good readings are presented as registered humidity/temperature bytes with a one-cycle valid strobe for the display data stage. A 1 µs time base is derived internally from the system clock.

---
 rtl/dht11_sensor_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dht11_sensor_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_ctrl.sv
// dht11_sensor_ctrl: single-wire DHT11 host controller.
// On an accepted start request it drives the host start pulse, captures the
// sensor's 40-bit frame (MSB first), and verifies the checksum. Good frames
// update the four data bytes and pulse o_valid. Timeouts and checksum errors
// set the sticky o_error and leave the previous data unchanged.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_start         one-cycle measurement request (ignored while busy)
//   dht_io          open-drain sensor line (driven 0 or released)
//   o_hum_int/dec   humidity bytes of the last good frame
//   o_temp_int/dec  temperature bytes of the last good frame
//   o_valid         one-cycle strobe when the data bytes update
//   o_busy          high from accepted start until back in IDLE
//   o_error         sticky timeout / checksum flag, cleared on next start
//   o_state         FSM state encoding for debug LEDs
module dht11_sensor_ctrl #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int START_REL_US  = 30,
  parameter int TIMEOUT_US    = 1000,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  inout  wire        dht_io,
  output logic [7:0] o_hum_int,
  output logic [7:0] o_hum_dec,
  output logic [7:0] o_temp_int,
  output logic [7:0] o_temp_dec,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_error,
  output logic [3:0] o_state
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [15:0] LOW_T = 16'(START_LOW_US);
  localparam logic [15:0] REL_T = 16'(START_REL_US);
  localparam logic [15:0] TO_T  = 16'(TIMEOUT_US);
  localparam logic [15:0] TH_T  = 16'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START_LOW = 4'd1,
    START_REL = 4'd2,
    WAIT_RESP = 4'd3,
    RESP_LOW  = 4'd4,
    RESP_HIGH = 4'd5,
    BIT_LOW   = 4'd6,
    BIT_HIGH  = 4'd7,
    CHECK     = 4'd8
  } state_t;

  state_t      state;
  logic        oe;
  logic [PW-1:0] pre;
  logic        us_tick;
  logic [15:0] us_cnt;
  logic [5:0]  bitcnt;
  logic [39:0] shreg;
  logic        s0, s1, sd;
  logic        rise, fall, waiting;
  logic [7:0]  sum;

  // Open-drain: only ever pull low, the external pull-up supplies the high.
  assign dht_io  = oe ? 1'b0 : 1'bz;
  assign o_state = state;

  // Free-running 1 us time base.
  assign us_tick = (pre == PW'(DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || us_tick) pre <= '0;
    else                pre <= pre + 1'b1;
  end

  // 2-FF synchronizer plus one delay stage for edge detection. Reset to the
  // idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      sd <= 1'b1;
    end else begin
      s0 <= dht_io;
      s1 <= s0;
      sd <= s1;
    end
  end
  assign rise = s1 & ~sd;
  assign fall = ~s1 & sd;

  assign waiting = (state == WAIT_RESP) || (state == RESP_LOW) ||
                   (state == RESP_HIGH) || (state == BIT_LOW) ||
                   (state == BIT_HIGH);
  assign sum = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      oe         <= 1'b0;
      us_cnt     <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      o_hum_int  <= '0;
      o_hum_dec  <= '0;
      o_temp_int <= '0;
      o_temp_dec <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (us_tick) us_cnt <= us_cnt + 1'b1;
      // Any wait/measure state that runs too long aborts the frame.
      if (waiting && us_cnt == TO_T) begin
        state   <= IDLE;
        o_error <= 1'b1;
        o_busy  <= 1'b0;
        us_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            us_cnt <= '0;
            if (i_start) begin
              state   <= START_LOW;
              oe      <= 1'b1;
              o_busy  <= 1'b1;
              o_error <= 1'b0;
              bitcnt  <= '0;
              shreg   <= '0;
            end
          end
          START_LOW: if (us_cnt == LOW_T) begin
            state  <= START_REL;
            oe     <= 1'b0;
            us_cnt <= '0;
          end
          START_REL: if (us_cnt == REL_T) begin
            state  <= WAIT_RESP;
            us_cnt <= '0;
          end
          WAIT_RESP: if (fall) begin state <= RESP_LOW;  us_cnt <= '0; end
          RESP_LOW:  if (rise) begin state <= RESP_HIGH; us_cnt <= '0; end
          RESP_HIGH: if (fall) begin state <= BIT_LOW;   us_cnt <= '0; end
          BIT_LOW:   if (rise) begin state <= BIT_HIGH;  us_cnt <= '0; end
          BIT_HIGH: if (fall) begin
            // Bit value is the length of the high phase just ended.
            shreg  <= {shreg[38:0], (us_cnt > TH_T)};
            bitcnt <= bitcnt + 1'b1;
            us_cnt <= '0;
            state  <= (bitcnt == 6'd39) ? CHECK : BIT_LOW;
          end
          CHECK: begin
            if (sum == shreg[7:0]) begin
              o_hum_int  <= shreg[39:32];
              o_hum_dec  <= shreg[31:24];
              o_temp_int <= shreg[23:16];
              o_temp_dec <= shreg[15:8];
              o_valid    <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
            o_busy <= 1'b0;
            us_cnt <= '0;
            state  <= IDLE;
          end
          default: begin
            state  <= IDLE;
            oe     <= 1'b0;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_sensor_ctrl.sv
// Bench for dht11_sensor_ctrl: behavioural DHT11 sensor on a pulled-up line,
// expected transaction results queued by the stimulus and checked by a
// monitor each time o_busy falls.
`timescale 1ns/1ps
module tb_dht11_sensor_ctrl;

  localparam int CLK_HZ = 2_000_000;  // 500 ns period, 2 clocks per us

  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, sens_low = 1'b0;
  wire  dht_io;
  logic [7:0] o_hum_int, o_hum_dec, o_temp_int, o_temp_dec;
  logic o_valid, o_busy, o_error;
  logic [3:0] o_state;

  pullup (dht_io);
  assign dht_io = sens_low ? 1'b0 : 1'bz;

  dht11_sensor_ctrl #(
    .CLK_FREQ_HZ(CLK_HZ), .START_LOW_US(50), .START_REL_US(30),
    .TIMEOUT_US(1000), .BIT_THRESH_US(40)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .dht_io(dht_io),
    .o_hum_int(o_hum_int), .o_hum_dec(o_hum_dec),
    .o_temp_int(o_temp_int), .o_temp_dec(o_temp_dec),
    .o_valid(o_valid), .o_busy(o_busy), .o_error(o_error), .o_state(o_state)
  );

  always #250 clk = ~clk;

  typedef struct {
    logic       err;
    int         vcnt;
    logic [7:0] hi, hd, ti, td;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   vseen = 0;
  logic busy_d = 1'b0;
  int   bit_idx = -1;
  logic bit_hi = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic err, input int vcnt, input logic [7:0] hi,
                      input logic [7:0] hd, input logic [7:0] ti, input logic [7:0] td);
    exp_t e;
    e.err = err; e.vcnt = vcnt; e.hi = hi; e.hd = hd; e.ti = ti; e.td = td;
    q.push_back(e);
  endtask

  // Monitor: a transaction ends when o_busy falls (done, error or reset).
  always @(negedge clk) begin
    int v;
    exp_t e;
    v = vseen + (o_valid ? 1 : 0);
    if (busy_d && !o_busy) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_txn: got end-of-transaction want none");
      end else begin
        e = q.pop_front();
        chk("txn_error", o_error, e.err);
        chk("txn_valid_cnt", v, e.vcnt);
        chk("txn_data", {o_hum_int, o_hum_dec, o_temp_int, o_temp_dec},
            {e.hi, e.hd, e.ti, e.td});
      end
      v = 0;
    end
    vseen  = v;
    busy_d = o_busy;
  end

  task automatic start_pulse();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_line(input logic v, input real tmo_ns, output bit ok);
    real t0;
    t0 = $realtime;
    ok = 1'b1;
    while (dht_io !== v) begin
      if ($realtime - t0 > tmo_ns) begin ok = 1'b0; break; end
      #50;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1);
  endtask

  // Sensor: waits for the host start pulse, then answers with a full frame.
  task automatic sensor_frame(input logic [39:0] f, input bit check_low);
    bit ok;
    real t0, dur;
    wait_line(1'b0, 200_000.0, ok);
    chk("start_seen", ok, 1);
    if (ok) begin
      t0 = $realtime;
      wait_line(1'b1, 100_000.0, ok);
      dur = $realtime - t0;
      if (check_low) chk("start_low_50us", (ok && dur >= 49_000.0 && dur <= 51_000.0), 1);
      #40_000;
      sens_low = 1'b1; #80_000;
      sens_low = 1'b0; #80_000;
      for (int i = 39; i >= 0; i--) begin
        bit_idx = 39 - i;
        bit_hi = 1'b0; sens_low = 1'b1; #50_000;
        bit_hi = 1'b1; sens_low = 1'b0;
        if (f[i]) #70_000; else #28_000;
      end
      bit_hi = 1'b0; sens_low = 1'b1; #50_000;
      sens_low = 1'b0;
      bit_idx = -1;
    end
  endtask

  task automatic run_frame(input logic [39:0] f, input bit check_low);
    fork
      start_pulse();
      sensor_frame(f, check_low);
    join
    wait_idle("frame_done");
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #45_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    real t0, dt;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", o_state, 0);
    chk("rst_data", {o_hum_int, o_hum_dec, o_temp_int, o_temp_dec}, 0);
    chk("rst_flags", {o_valid, o_busy, o_error}, 0);
    chk("rst_line", dht_io, 1);

    // Good frame, also checks start pulse width
    push(1'b0, 1, 8'h37, 8'h00, 8'h19, 8'h00);
    run_frame(40'h37_00_19_00_50, 1'b1);

    // Bad checksum keeps previous data
    push(1'b1, 0, 8'h37, 8'h00, 8'h19, 8'h00);
    run_frame(40'h37_00_19_00_51, 1'b0);

    // No sensor: timeout exactly 1000 us after entering WAIT_RESP
    push(1'b1, 0, 8'h37, 8'h00, 8'h19, 8'h00);
    start_pulse();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_state == 4'd3) begin ok = 1'b1; break; end
    end
    chk("reach_wait_resp", ok, 1);
    chk("err_cleared_on_start", o_error, 0);
    t0 = $realtime;
    ok = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (o_error) begin ok = 1'b1; break; end
    end
    dt = $realtime - t0;
    chk("timeout_1000us", (ok && dt >= 999_000.0 && dt <= 1_001_000.0), 1);
    wait_idle("timeout_idle");
    repeat (10) @(posedge clk);

    // All-ones payload: every bit is a 70 us high
    push(1'b0, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_frame(40'hFF_FF_FF_FF_FC, 1'b0);

    // Start request mid-frame is ignored
    push(1'b0, 1, 8'h41, 8'h05, 8'h1A, 8'h03);
    fork
      run_frame(40'h41_05_1A_03_63, 1'b0);
      begin #1_500_000; start_pulse(); end
    join

    // Reset during bit 20 (high phase): everything clears immediately
    push(1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    fork
      begin start_pulse(); end
      sensor_frame(40'h37_00_19_00_50, 1'b0);
      begin
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
          #500;
          if (bit_idx == 20 && bit_hi) begin ok = 1'b1; break; end
        end
        chk("reach_bit20", ok, 1);
        #5_000;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_state", o_state, 0);
        chk("midrst_line", dht_io, 1);
        chk("midrst_data", {o_hum_int, o_hum_dec, o_temp_int, o_temp_dec}, 0);
        chk("midrst_flags", {o_valid, o_busy, o_error}, 0);
      end
    join
    repeat (10) @(posedge clk);

    // A following start succeeds
    push(1'b0, 1, 8'h37, 8'h00, 8'h19, 8'h00);
    run_frame(40'h37_00_19_00_50, 1'b0);

    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
